uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Serial receive framer for the calculator link: it recovers bytes from the asynchronous line driven by the host, checks the parity and stop bits, and presents each byte with a one-cycle done strobe. It sits directly upstream of the interface/ALU sequencing stage and supplies its `rx_done` / `rx_data` / `rx_parity` inputs. Bit timing comes from an external oversampling tick, so the same baud generator can also serve the transmitter.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, sent LSB first.
- `STOP_WIDTH`, 1: number of stop bits, 1 or 2.
- `PARITY_WIDTH`, 1: 1 means a parity bit follows the data; 0 means no parity.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `OVERSAMPLE`, 16: number of ticks per bit; must be even and at least 8.
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_tick`  in  1  one-cycle pulse, OVERSAMPLE pulses per bit period.
- `i_rx`  in  1  serial line; idle level is high; asynchronous to `i_clock`.
- `o_rx_data`  out  DATA_WIDTH  last received byte; holds until the next done pulse.
- `o_parity`  out  max(PARITY_WIDTH,1)  received parity bit; 0 when PARITY_WIDTH=0.
- `o_rx_done`  out  1  one-cycle pulse when a frame completes.
- `o_parity_err`  out  1  parity mismatch for the last frame.
- `o_frame_err`  out  1  a stop bit was sampled low in the last frame.
- `o_busy`  out  1  high while the FSM is in any state other than IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer; the synchronizer resets to 1. A third register holds the previous synced value for falling-edge detection.
- Tick counter `tcnt`, $\lceil\log_2(\text{OVERSAMPLE})\rceil$ bits, advances only on `i_tick`. Bit counter `bcnt` counts data bits and stop bits.
- FSM states and transitions:
  - IDLE: on a synced falling edge (previous 1, current 0), clear `tcnt` and go to START. A line held low never retriggers a frame.
  - START: on the tick where `tcnt` = OVERSAMPLE/2−1 (mid-bit):
    - synced rx = 1: glitch, return to IDLE with no outputs changed;
    - otherwise clear `tcnt` and go to DATA.
  - DATA: on the tick where `tcnt` = OVERSAMPLE−1, right-shift the sample into a shift register (LSB first) and clear `tcnt`. After DATA_WIDTH samples, go to PARITY if PARITY_WIDTH=1, else go to STOP.
  - PARITY: sample once at OVERSAMPLE−1, then go to STOP.
  - STOP: sample at OVERSAMPLE−1 for each stop bit. Any stop sample equal to 0 sets an internal frame-error flag. After the last stop sample, update the outputs and return to IDLE in the same cycle.
- Frame completion, one cycle:
  - `o_rx_data` ← shift register;
  - `o_parity` ← parity sample;
  - `o_parity_err` ← (^data ^ parity ^ PARITY_ODD), forced to 0 when PARITY_WIDTH=0;
  - `o_frame_err` ← frame-error flag;
  - `o_rx_done` = 1.
- Errored frames still assert done and deliver their data. The consumer decides whether to discard.
- Error flags and data hold until the next completed frame. A rejected start glitch leaves them untouched.
- `i_rx` is ignored while not in IDLE. A falling edge that occurs during STOP is not detected if the line is still low in IDLE; this is a break condition and needs the line to return high first.

## Timing
- Reset values: `o_rx_data` = 0, `o_parity` = 0, `o_rx_done` = 0, `o_parity_err` = 0, `o_frame_err` = 0, `o_busy` = 0; FSM in IDLE; counters at 0; synchronizer at 1.
- Reset asserted mid-frame clears everything immediately. No done pulse is produced for the aborted frame.
- Edge detection latency: 3 clocks from `i_rx` falling to entering START (2 synchronizer stages plus the edge register).
- Frame latency: `o_rx_done` is a registered output, asserted the clock after the final stop-sample tick. That tick is OVERSAMPLE/2 + OVERSAMPLE·(DATA_WIDTH + PARITY_WIDTH + STOP_WIDTH) ticks after entering START. With defaults: 8 + 16·10 = 168 ticks.
- `o_rx_done` is exactly one `i_clock` cycle wide and independent of tick spacing. Every output updates in the same cycle as `o_rx_done`.
- The FSM returns to IDLE on the cycle `o_rx_done` asserts, so the receiver can accept a new start edge half a bit before the nominal end of the stop bit. This tolerates up to ±3% baud mismatch.
- `i_tick` is asserted on consecutive cycles only when OVERSAMPLE·baud equals the clock frequency. That case is legal; the counters simply advance every cycle.

## Test plan
- Defaults, even parity; send 0xA5 with parity 0 and stop 1 → one `o_rx_done` pulse, `o_rx_data` = 0xA5, `o_parity` = 0, both error flags 0, done 168 ticks after the start edge (±3 clocks).
- Send 0x3C with parity bit 1 (wrong for even) → done pulse, `o_rx_data` = 0x3C, `o_parity_err` = 1. Then send 0x01 with parity 1 → `o_parity_err` = 0.
- Send 0x55 with the stop bit low, then the line high → done pulse, `o_frame_err` = 1, `o_rx_data` = 0x55. Holding the line low afterwards produces no further done pulse.
- Low pulse of 5 ticks on an idle line → no done pulse, `o_busy` returns to 0 after 8 ticks, outputs unchanged.
- Back-to-back frames 0x12, 0x34, 0x56 with no idle gap, each with correct parity → three done pulses in order, data 0x12, 0x34, 0x56, no errors.
- Assert `i_reset` low during data bit 4 of a frame, release it, then send 0xFF with parity 0 → no pulse for the aborted frame, outputs read 0 during reset, next frame gives 0xFF with no errors.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_if
// Purpose  : Received-frame bundle from the UART framer to its consumer.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  parity;
    logic                  rx_done;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (output rx_data, parity, rx_done, parity_err, frame_err, busy);
    modport slave  (input  rx_data, parity, rx_done, parity_err, frame_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Oversampled UART receive framer with parity/stop checking.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_WIDTH   = 1,
    parameter int PARITY_WIDTH = 1,
    parameter int PARITY_ODD   = 0,
    parameter int OVERSAMPLE   = 16
) (
    input  wire logic       i_clock,
    input  wire logic       i_reset,
    input  wire logic       i_tick,
    input  wire logic       i_rx,
    uart_rx_frame_if.master rx_if
);
    localparam int C_TCNT_W = $clog2(OVERSAMPLE);
    localparam int C_BCNT_W = $clog2(DATA_WIDTH + STOP_WIDTH + 1);
    localparam logic [C_TCNT_W-1:0] C_T_MID   = C_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [C_TCNT_W-1:0] C_T_END   = C_TCNT_W'(OVERSAMPLE - 1);
    localparam logic [C_TCNT_W-1:0] C_T_ONE   = C_TCNT_W'(1);
    localparam logic [C_BCNT_W-1:0] C_B_DLAST = C_BCNT_W'(DATA_WIDTH - 1);
    localparam logic [C_BCNT_W-1:0] C_B_SLAST = C_BCNT_W'(STOP_WIDTH - 1);
    localparam logic [C_BCNT_W-1:0] C_B_ONE   = C_BCNT_W'(1);
    localparam logic                C_ODD     = (PARITY_ODD != 0);
    localparam logic                C_HAS_PAR = (PARITY_WIDTH != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic [C_TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [C_BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  parity_q, parity_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic                  frame_err_q, frame_err_d;
    logic                  w_fall;
    logic                  w_bit_end;

    // Line sync plus previous-value register; all idle high so reset is not an edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign w_fall    = prev_q & ~sync2_q;
    assign w_bit_end = i_tick && (tcnt_q == C_T_END);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ferr_q      <= 1'b0;
            rx_data_q   <= '0;
            parity_q    <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            ferr_q      <= ferr_d;
            rx_data_q   <= rx_data_d;
            parity_q    <= parity_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ferr_d      = ferr_q;
        rx_data_d   = rx_data_q;
        parity_d    = parity_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        frame_err_d = frame_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (tcnt_q == C_T_MID) begin
                        tcnt_d  = '0;
                        // A line already back high at mid-start is noise, not a frame.
                        state_d = sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + C_T_ONE;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    tcnt_d  = '0;
                    shift_d = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    if (bcnt_q == C_B_DLAST) begin
                        bcnt_d  = '0;
                        state_d = C_HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + C_B_ONE;
                    end
                end else if (i_tick) begin
                    tcnt_d = tcnt_q + C_T_ONE;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    tcnt_d  = '0;
                    par_d   = sync2_q;
                    state_d = S_STOP;
                end else if (i_tick) begin
                    tcnt_d = tcnt_q + C_T_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    tcnt_d = '0;
                    ferr_d = ferr_q | ~sync2_q;
                    if (bcnt_q == C_B_SLAST) begin
                        bcnt_d      = '0;
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        rx_data_d   = shift_q;
                        parity_d    = par_q;
                        perr_d      = C_HAS_PAR & (^shift_q ^ par_q ^ C_ODD);
                        frame_err_d = ferr_q | ~sync2_q;
                    end else begin
                        bcnt_d = bcnt_q + C_B_ONE;
                    end
                end else if (i_tick) begin
                    tcnt_d = tcnt_q + C_T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.parity     = parity_q;
    assign rx_if.rx_done    = done_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.busy       = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_rx_frame: frame-level model with a per-cycle compare process
// plus literal expectations after each directed scenario.
module tb_uart_rx_frame;
    localparam int OS = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [1:0] tdiv  = 2'd0;
    logic       tick;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    time t_start = 0;
    time t_done  = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t held = '0;

    always #5 clk = ~clk;

    // One tick every fourth clock, changed away from the active edge.
    initial forever begin
        @(negedge clk);
        tdiv = tdiv + 2'd1;
    end
    assign tick = (tdiv == 2'd0);

    uart_rx_frame_if #(.DATA_WIDTH(8)) rif ();

    uart_rx_frame #(
        .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY_WIDTH(1), .PARITY_ODD(0), .OVERSAMPLE(OS)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_tick (tick),
        .i_rx   (rx),
        .rx_if  (rif)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame model: each done pops the next expected frame; outputs must hold otherwise.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held = '0;
            check("reset_done_busy", {30'd0, rif.rx_done, rif.busy}, 32'd0);
        end else if (rif.rx_done) begin
            done_cnt++;
            t_done = $time;
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else held = exp_q.pop_front();
        end
        check("outputs_vs_model", {21'd0, rif.rx_data, rif.parity, rif.parity_err, rif.frame_err},
              {21'd0, held.d, held.p, held.pe, held.fe});
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        exp_t e;
        e.d  = d;
        e.p  = p;
        e.pe = (^d) ^ p;
        e.fe = ~stop;
        exp_q.push_back(e);
        t_start = $time;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    task automatic check_outs(input string name, input logic [7:0] d, input logic p,
                              input logic pe, input logic fe);
        check({name, "_data"}, {24'd0, rif.rx_data}, {24'd0, d});
        check({name, "_par"},  {31'd0, rif.parity}, {31'd0, p});
        check({name, "_perr"}, {31'd0, rif.parity_err}, {31'd0, pe});
        check({name, "_ferr"}, {31'd0, rif.frame_err}, {31'd0, fe});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lat;
        logic [7:0] ab;
        repeat (5) @(negedge clk);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_busy", {31'd0, rif.busy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        send_bit(1'b1);

        // Nominal frame plus latency.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_done_cnt", done_cnt, 1);
        check_outs("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        lat = int'((t_done - t_start) / 10);
        check("a5_latency_ok", {31'd0, (lat >= 670 && lat <= 677)}, 32'd1);
        send_bit(1'b1);

        // Parity error, then a correct-parity frame clears it.
        send_frame(8'h3C, 1'b1, 1'b1);
        check_outs("3c", 8'h3C, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1);
        send_frame(8'h01, 1'b1, 1'b1);
        check_outs("01", 8'h01, 1'b1, 1'b0, 1'b0);
        check("01_done_cnt", done_cnt, 3);
        send_bit(1'b1);

        // Stop bit low, line held low afterwards: break, no retrigger.
        send_frame(8'h55, 1'b0, 1'b0);
        wait_ticks(3 * OS);
        check("break_done_cnt", done_cnt, 4);
        check("break_busy", {31'd0, rif.busy}, 32'd0);
        check_outs("55", 8'h55, 1'b0, 1'b0, 1'b1);
        rx = 1'b1;
        wait_ticks(2 * OS);

        // Short glitch is rejected at mid-start.
        rx = 1'b0;
        wait_ticks(5);
        check("glitch_busy_hi", {31'd0, rif.busy}, 32'd1);
        rx = 1'b1;
        wait_ticks(8);
        check("glitch_busy_lo", {31'd0, rif.busy}, 32'd0);
        check("glitch_done_cnt", done_cnt, 4);
        check_outs("glitch", 8'h55, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        send_frame(8'h56, 1'b0, 1'b1);
        send_bit(1'b1);
        check("b2b_done_cnt", done_cnt, 7);
        check_outs("56", 8'h56, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4 aborts the frame silently.
        base = done_cnt;
        ab = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(ab[i]);
        rx = ab[4];
        wait_ticks(8);
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        check_outs("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("abort_busy", {31'd0, rif.busy}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        send_bit(1'b1);
        send_bit(1'b1);
        check("abort_no_done", done_cnt, base);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b1);
        check("ff_done_cnt", done_cnt, base + 1);
        check_outs("ff", 8'hFF, 1'b0, 1'b0, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
